store_buffer: RTL and testbench
===============================

# store_buffer

Four-entry in-order store buffer between the MEM stage and the data memory of the 64-bit pipelined ARM CPU. It accepts retired STUR/STURB requests from the MEM stage and drains them to data memory through a valid/ready write port. It forwards buffered data to younger LDUR/LDURB loads, and requests a stall when a load only partly overlaps a buffered store. This decouples the pipeline from data-memory write latency.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_W, 64, address width
- DATA_W, 64, data width
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all entries and pointers
- st_valid  in  1  MEM-stage store request
- st_addr  in  64  store byte address
- st_data  in  64  store data; byte stores use st_data[7:0]
- st_size  in  4  4'b1000 = 8 bytes, 4'b0001 = 1 byte
- st_ready  out  1  buffer can accept a store (count < DEPTH)
- ld_valid  in  1  MEM-stage load lookup request
- ld_addr  in  64  load byte address
- ld_size  in  4  encoded as st_size
- ld_hit  out  1  load is fully satisfied from the buffer
- ld_data  out  64  forwarded data; byte loads are zero-extended
- ld_stall  out  1  partial overlap; the pipeline holds the load
- mem_wr_valid  out  1  head entry presented to data memory
- mem_wr_addr  out  64  head address
- mem_wr_data  out  64  head data
- mem_wr_size  out  4  head size
- mem_wr_ready  in  1  data memory accepts the head this edge
- empty  out  1  count == 0
- count  out  3  occupied entries, 0..DEPTH

## Operation
- Storage: circular array of {addr, data, size}. It uses head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a separate count register.
- Enqueue: when st_valid && st_ready, the store writes the entry at tail, tail increments, and count increments.
- Dequeue: when mem_wr_valid && mem_wr_ready, head increments and count decrements.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Full (count == DEPTH): st_ready = 0, even if a dequeue occurs in the same cycle. A st_valid that arrives while full is ignored; the stalling of the MEM stage is the caller's job.
- Empty: mem_wr_valid = 0. mem_wr_addr, mem_wr_data and mem_wr_size still show the head slot contents but are don't-care.
- Byte mask per access: size 8 gives 8'hFF; size 1 gives 1 << addr[2:0]. 8-byte accesses are 8-byte aligned; no misalignment check is made.
- Load lookup is combinational on the current registered contents, including an entry that is being dequeued this cycle.
  - Candidates are entries with matching addr[63:3] and a nonzero mask intersection with the load.
  - Only the youngest candidate (nearest tail) is used.
  - If the candidate mask covers the load mask: ld_hit = 1 and ld_stall = 0.
  - 8-byte load hit: ld_data = entry data.
  - Byte load hitting an 8-byte entry: ld_data = {56'b0, data[8*ld_addr[2:0] +: 8]}.
  - Byte load hitting a byte entry: ld_data = {56'b0, data[7:0]}.
  - If the candidate only partially covers the load: ld_hit = 0 and ld_stall = 1.
  - No candidate: ld_hit = 0 and ld_stall = 0; the load proceeds to data memory.
- When ld_valid = 0: ld_hit = 0, ld_stall = 0, ld_data = 0.

## Timing
- Reset, applied synchronously at the edge:
  - head, tail and count = 0; all entries zeroed; outputs settle the same cycle.
  - Resulting outputs: mem_wr_valid = 0, mem_wr_addr = mem_wr_data = 0, mem_wr_size = 0, st_ready = 1, empty = 1, count = 0.
- Reset asserted mid-drain: all pending stores are discarded and mem_wr_valid = 0 after the edge. Data memory must not count a concurrent mem_wr_ready as an accepted write.
- Latency from a store accepted at edge N to:
  - mem_wr_valid high after edge N, when the buffer was empty;
  - the store being visible to load lookup after edge N.
- A store and a load presented in the same cycle: the store is not visible to that load.
- Write handshake: mem_wr_valid, addr, data and size stay stable until the edge where mem_wr_ready = 1. mem_wr_valid never depends combinationally on mem_wr_ready.
- Throughput: one enqueue and one dequeue per cycle.

## Test plan
- Reset, then a single 8-byte store (addr 0x10, data 0xDEADBEEF_CAFEF00D) -> count = 1 after one edge, mem_wr_valid = 1 with the matching fields; with mem_wr_ready = 1 for one cycle -> empty = 1.
- Four stores with mem_wr_ready = 0 -> count = 4, st_ready = 0, a fifth st_valid is ignored. Hold mem_wr_ready = 1 -> the four stores drain in order and the pointers wrap correctly on a second round of four.
- 8-byte store to 0x20 (data 0x1122334455667788), then byte load at 0x23 -> ld_hit = 1, ld_data = 0x55.
- Byte store 0xAB to 0x28, then 8-byte load at 0x28 -> ld_stall = 1, ld_hit = 0. A byte load at 0x28 -> ld_hit = 1, ld_data = 0xAB.
- 8-byte stores to 0x30 of 0x1 and then 0x2, then a load at 0x30 -> ld_data = 0x2 (youngest wins). Also check this while the older entry is being dequeued.
- Three entries pending with mem_wr_valid = 1, then reset for one cycle -> after the edge count = 0, mem_wr_valid = 0, st_ready = 1, and no further writes appear.

Source files
------------

// File: rtl/store_buffer_if.sv
// store_buffer_if: MEM-stage store/load lookup and data-memory write port bundle; slave = buffer side, master = pipeline/memory side
interface store_buffer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CW = 3
);
  logic st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [3:0] st_size;
  logic st_ready;
  logic ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [3:0] ld_size;
  logic ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic ld_stall;
  logic mem_wr_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [3:0] mem_wr_size;
  logic mem_wr_ready;
  logic empty;
  logic [CW-1:0] count;
  modport slave (
    input st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size, mem_wr_ready,
    output st_ready, ld_hit, ld_data, ld_stall, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_size, empty, count
  );
  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size, mem_wr_ready,
    input st_ready, ld_hit, ld_data, ld_stall, mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_size, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order store buffer with youngest-match load forwarding; ports clk, reset (sync, active-high), bus (store_buffer_if.slave)
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [3:0] r_size [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic w_enq, w_deq, w_found, w_c8, w_l8, w_hit, w_cover;
  logic [7:0] w_lmask, w_cmask, w_emask, w_byte;
  logic [DATA_W-1:0] w_cdata;
  logic [PW-1:0] w_slot;
  function automatic logic [7:0] f_mask(input logic [2:0] a, input logic [3:0] s);
    return s == 4'b1000 ? 8'hFF : 8'h01 << a;
  endfunction
  assign w_enq = bus.st_valid && bus.st_ready;
  assign w_deq = bus.mem_wr_valid && bus.mem_wr_ready;
  assign bus.st_ready = r_count < CW'(DEPTH);
  assign bus.mem_wr_valid = r_count != '0;
  assign bus.mem_wr_addr = r_addr[r_head];
  assign bus.mem_wr_data = r_data[r_head];
  assign bus.mem_wr_size = r_size[r_head];
  assign bus.empty = r_count == '0;
  assign bus.count = r_count;
  assign w_lmask = f_mask(bus.ld_addr[2:0], bus.ld_size);
  assign w_l8 = bus.ld_size == 4'b1000;
  always_comb begin
    w_found = 1'b0;
    w_cmask = '0;
    w_cdata = '0;
    w_c8 = 1'b0;
    w_slot = '0;
    w_emask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot = r_head + PW'(i);
      w_emask = f_mask(r_addr[w_slot][2:0], r_size[w_slot]);
      if (CW'(i) < r_count && r_addr[w_slot][ADDR_W-1:3] == bus.ld_addr[ADDR_W-1:3] && |(w_emask & w_lmask)) begin
        w_found = 1'b1;
        w_cmask = w_emask;
        w_cdata = r_data[w_slot];
        w_c8 = r_size[w_slot] == 4'b1000;
      end
    end
  end
  assign w_cover = (w_cmask & w_lmask) == w_lmask;
  assign w_hit = bus.ld_valid && w_found && w_cover;
  assign bus.ld_hit = w_hit;
  assign bus.ld_stall = bus.ld_valid && w_found && !w_cover;
  assign w_byte = w_c8 ? w_cdata[8*bus.ld_addr[2:0] +: 8] : w_cdata[7:0];
  assign bus.ld_data = !w_hit ? '0 : w_l8 ? w_cdata : {{(DATA_W-8){1'b0}}, w_byte};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_size[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail] <= bus.st_addr;
        r_data[r_tail] <= bus.st_data;
        r_size[r_tail] <= bus.st_size;
      end
      r_tail <= r_tail + PW'(w_enq);
      r_head <= r_head + PW'(w_deq);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a queue-based reference model
module tb_store_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  store_buffer_if sb();
  store_buffer dut (.clk(clk), .reset(reset), .bus(sb));
  typedef struct {logic [63:0] a; logic [63:0] d; logic [3:0] s;} ent_t;
  ent_t q[$];
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] bmask(input logic [63:0] a, input logic [3:0] s);
    logic [7:0] one;
    one = 8'd1;
    return s == 4'd8 ? 8'hFF : one << a[2:0];
  endfunction
  task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd, input logic [3:0] ss,
                       input logic lv, input logic [63:0] la, input logic [3:0] ls, input logic rdy);
    sb.st_valid = sv; sb.st_addr = sa; sb.st_data = sd; sb.st_size = ss;
    sb.ld_valid = lv; sb.ld_addr = la; sb.ld_size = ls; sb.mem_wr_ready = rdy;
  endtask
  task automatic cyc();
    logic hit, stall, done, enq, deq;
    logic [63:0] d;
    logic [7:0] em, lm;
    ent_t e;
    #1;
    hit = 0; stall = 0; d = 0; done = 0;
    lm = bmask(sb.ld_addr, sb.ld_size);
    if (sb.ld_valid)
      for (int i = q.size() - 1; i >= 0; i--) begin
        em = bmask(q[i].a, q[i].s);
        if (!done && q[i].a[63:3] == sb.ld_addr[63:3] && (em & lm) != 0) begin
          done = 1;
          if ((em & lm) == lm) begin
            hit = 1;
            d = sb.ld_size == 4'd8 ? q[i].d :
                ((q[i].s == 4'd8 ? q[i].d >> ({61'b0, sb.ld_addr[2:0]} * 8) : q[i].d) & 64'hFF);
          end else stall = 1;
        end
      end
    chk("ld_hit", sb.ld_hit, hit);
    chk("ld_stall", sb.ld_stall, stall);
    chk("ld_data", sb.ld_data, d);
    chk("count", sb.count, q.size());
    chk("empty", sb.empty, q.size() == 0);
    chk("st_ready", sb.st_ready, q.size() < 4);
    chk("wr_valid", sb.mem_wr_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("wr_addr", sb.mem_wr_addr, q[0].a);
      chk("wr_data", sb.mem_wr_data, q[0].d);
      chk("wr_size", sb.mem_wr_size, q[0].s);
    end
    enq = sb.st_valid && q.size() < 4;
    deq = q.size() > 0 && sb.mem_wr_ready;
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (deq) e = q.pop_front();
      if (enq) q.push_back('{sb.st_addr, sb.st_data, sb.st_size});
    end
    #1;
  endtask
  task automatic idle(input logic rdy);
    drive(0, 0, 0, 4'd8, 0, 0, 4'd8, rdy);
  endtask
  initial begin
    logic s8, l8;
    logic [63:0] sa, la;
    idle(0);
    @(posedge clk);
    #1;
    reset = 0;
    chk("rst_count", sb.count, 0);
    chk("rst_wr_valid", sb.mem_wr_valid, 0);
    chk("rst_st_ready", sb.st_ready, 1);
    chk("rst_empty", sb.empty, 1);
    chk("rst_wr_addr", sb.mem_wr_addr, 0);
    chk("rst_wr_data", sb.mem_wr_data, 0);
    drive(1, 64'h10, 64'hDEADBEEF_CAFEF00D, 4'd8, 0, 0, 4'd8, 0);
    cyc();
    idle(0);
    #1;
    chk("t1_count", sb.count, 1);
    chk("t1_wr_valid", sb.mem_wr_valid, 1);
    chk("t1_wr_data", sb.mem_wr_data, 64'hDEADBEEF_CAFEF00D);
    chk("t1_wr_addr", sb.mem_wr_addr, 64'h10);
    idle(1);
    cyc();
    chk("t1_empty", sb.empty, 1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1, 64'h100 + 64'(8 * k), 64'(k + 1 + 16 * r), 4'd8, 0, 0, 4'd8, 0);
        cyc();
      end
      drive(1, 64'h200, 64'h99, 4'd8, 0, 0, 4'd8, 0);
      #1;
      chk("t2_full_count", sb.count, 4);
      chk("t2_full_ready", sb.st_ready, 0);
      cyc();
      chk("t2_ignored", sb.count, 4);
      for (int k = 0; k < 4; k++) begin
        idle(1);
        #1;
        chk("t2_order", sb.mem_wr_data, 64'(k + 1 + 16 * r));
        cyc();
      end
      chk("t2_drained", sb.empty, 1);
    end
    drive(1, 64'h20, 64'h1122334455667788, 4'd8, 0, 0, 4'd8, 0);
    cyc();
    drive(0, 0, 0, 4'd8, 1, 64'h23, 4'd1, 0);
    #1;
    chk("t3_hit", sb.ld_hit, 1);
    chk("t3_data", sb.ld_data, 64'h55);
    cyc();
    drive(1, 64'h28, 64'hAB, 4'd1, 0, 0, 4'd8, 0);
    cyc();
    drive(0, 0, 0, 4'd8, 1, 64'h28, 4'd8, 0);
    #1;
    chk("t4_stall", sb.ld_stall, 1);
    chk("t4_nohit", sb.ld_hit, 0);
    cyc();
    drive(0, 0, 0, 4'd8, 1, 64'h28, 4'd1, 0);
    #1;
    chk("t4_hit", sb.ld_hit, 1);
    chk("t4_data", sb.ld_data, 64'hAB);
    cyc();
    idle(1);
    repeat (3) cyc();
    drive(1, 64'h30, 64'h1, 4'd8, 0, 0, 4'd8, 0);
    cyc();
    drive(1, 64'h30, 64'h2, 4'd8, 0, 0, 4'd8, 0);
    cyc();
    drive(0, 0, 0, 4'd8, 1, 64'h30, 4'd8, 1);
    #1;
    chk("t5_young_deq", sb.ld_data, 64'h2);
    cyc();
    #1;
    chk("t5_young", sb.ld_data, 64'h2);
    cyc();
    idle(1);
    repeat (2) cyc();
    for (int k = 0; k < 3; k++) begin
      drive(1, 64'h40 + 64'(8 * k), 64'(k + 7), 4'd8, 0, 0, 4'd8, 0);
      cyc();
    end
    idle(1);
    reset = 1;
    #1;
    chk("t6_pre_valid", sb.mem_wr_valid, 1);
    cyc();
    reset = 0;
    chk("t6_count", sb.count, 0);
    chk("t6_wr_valid", sb.mem_wr_valid, 0);
    chk("t6_st_ready", sb.st_ready, 1);
    chk("t6_wr_addr", sb.mem_wr_addr, 0);
    repeat (3) cyc();
    for (int n = 0; n < 600; n++) begin
      s8 = 1'($urandom % 2);
      l8 = 1'($urandom % 2);
      sa = 64'(($urandom % 8) * 8) + (s8 ? 64'd0 : 64'($urandom % 8));
      la = 64'(($urandom % 8) * 8) + (l8 ? 64'd0 : 64'($urandom % 8));
      drive(1'($urandom % 2), sa, {$urandom, $urandom}, s8 ? 4'd8 : 4'd1,
            1'($urandom % 4 != 0), la, l8 ? 4'd8 : 4'd1, 1'($urandom % 3 == 0));
      reset = ($urandom % 97) == 0;
      cyc();
    end
    reset = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
